// File: rtl/memory_hierarchy_pkg.sv
// Shared widths, FSM state encoding, cache-line layout and the main-memory
// initial-image function for the memory_hierarchy block.
package memory_hierarchy_pkg;

  localparam int ADDR_W       = 15;
  localparam int DATA_W       = 32;
  localparam int INDEX_W      = 8;
  localparam int OFFSET_W     = 2;
  localparam int TAG_W        = ADDR_W - INDEX_W - OFFSET_W;
  localparam int BLOCK_WORDS  = 1 << OFFSET_W;
  localparam int LINES        = 1 << INDEX_W;
  localparam int BLOCK_ADDR_W = ADDR_W - OFFSET_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic [BLOCK_WORDS-1:0][DATA_W-1:0] block_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    block_t           words;
  } cache_line_t;

  // Elaboration-time memory image: every word holds its own address.
  function automatic logic [DATA_W-1:0] mem_init_word(input logic [ADDR_W-1:0] a);
    return {{(DATA_W-ADDR_W){1'b0}}, a};
  endfunction

endpackage

// File: rtl/main_memory.sv
// Read-only 32K-word backing store with a 4-word block read port. The image
// is a constant of the design, so reset can never disturb it.
module main_memory
  import memory_hierarchy_pkg::*;
(
  input  logic [BLOCK_ADDR_W-1:0] block_addr,
  output block_t                  block
);

  // Assemble the four words of the addressed block from the memory image.
  always_comb begin
    block = '0;
    for (int i = 0; i < BLOCK_WORDS; i++) begin
      block[i] = mem_init_word({block_addr, OFFSET_W'(i)});
    end
  end

endmodule

// File: rtl/memory_hierarchy.sv
// Direct-mapped read-only word cache in front of main_memory, driven by an
// IDLE/FETCH/DONE handshake FSM. Define MEMORY_HIERARCHY_STATS_EN for hit/miss counters.
module memory_hierarchy
  import memory_hierarchy_pkg::*;
#(
  parameter int MEM_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic              MemRead,
  output logic [DATA_W-1:0] data,
  output logic              DataReady,
  output logic              HMbar
`ifdef MEMORY_HIERARCHY_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  state_t               state;
  state_t               state_next;
  logic [ADDR_W-1:0]    addr_lat;
  logic [CNT_W-1:0]     count;
  logic [LINES-1:0]     valid;
  logic [TAG_W-1:0]     tags  [LINES];
  block_t               words [LINES];
  cache_line_t          lookup;
  block_t               fetched;
  logic                 hit;
  logic                 fill_done;
  logic [DATA_W-1:0]    data_next;
  logic                 ready_next;
  logic                 hmbar_next;

  logic [TAG_W-1:0]     in_tag;
  logic [INDEX_W-1:0]   in_index;
  logic [OFFSET_W-1:0]  in_offset;
  logic [TAG_W-1:0]     lat_tag;
  logic [INDEX_W-1:0]   lat_index;
  logic [OFFSET_W-1:0]  lat_offset;

  assign in_tag     = address[ADDR_W-1:INDEX_W+OFFSET_W];
  assign in_index   = address[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign in_offset  = address[OFFSET_W-1:0];
  assign lat_tag    = addr_lat[ADDR_W-1:INDEX_W+OFFSET_W];
  assign lat_index  = addr_lat[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign lat_offset = addr_lat[OFFSET_W-1:0];

  main_memory u_main_memory (
    .block_addr (addr_lat[ADDR_W-1:OFFSET_W]),
    .block      (fetched)
  );

  // Hit lookup uses the live address; the master holds it stable while MemRead=1.
  always_comb begin
    lookup.valid = valid[in_index];
    lookup.tag   = tags[in_index];
    lookup.words = words[in_index];
  end

  assign hit       = lookup.valid && (lookup.tag == in_tag);
  assign fill_done = (state == FETCH) && (count == CNT_W'(MEM_LATENCY - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (MemRead) begin
          state_next = hit ? DONE : FETCH;
        end else begin
          state_next = IDLE;
        end
      end
      FETCH: begin
        if (fill_done) begin
          state_next = DONE;
        end else begin
          state_next = FETCH;
        end
      end
      DONE: begin
        if (MemRead) begin
          state_next = DONE;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs; data and HMbar hold unless a request completes.
  always_comb begin
    data_next  = data;
    hmbar_next = HMbar;
    ready_next = DataReady;
    case (state)
      IDLE: begin
        if (MemRead && hit) begin
          data_next  = lookup.words[in_offset];
          hmbar_next = 1'b1;
          ready_next = 1'b1;
        end else begin
          ready_next = 1'b0;
        end
      end
      FETCH: begin
        if (fill_done) begin
          data_next  = fetched[lat_offset];
          hmbar_next = 1'b0;
          ready_next = 1'b1;
        end else begin
          ready_next = 1'b0;
        end
      end
      DONE: begin
        if (MemRead) begin
          ready_next = 1'b1;
        end else begin
          ready_next = 1'b0;
        end
      end
      default: ready_next = 1'b0;
    endcase
  end

  // Output registers, request latch, fetch counter and line valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data      <= {DATA_W{1'b0}};
      DataReady <= 1'b0;
      HMbar     <= 1'b0;
      addr_lat  <= {ADDR_W{1'b0}};
      count     <= {CNT_W{1'b0}};
      valid     <= {LINES{1'b0}};
    end else begin
      data      <= data_next;
      DataReady <= ready_next;
      HMbar     <= hmbar_next;
      if ((state == IDLE) && MemRead) begin
        addr_lat <= address;
        count    <= {CNT_W{1'b0}};
      end else if (state == FETCH) begin
        count <= count + CNT_W'(1);
      end else begin
        count <= count;
      end
      if (fill_done) begin
        valid[lat_index] <= 1'b1;
      end else begin
        valid <= valid;
      end
    end
  end

  // Tag and data storage; contents only matter once the valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tags[lat_index]  <= lat_tag;
      words[lat_index] <= fetched;
    end
  end

`ifdef MEMORY_HIERARCHY_STATS_EN
  // Count each completed request once, on the edge that enters DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else if ((state != DONE) && (state_next == DONE)) begin
      if (hmbar_next) begin
        hit_count <= hit_count + 32'd1;
      end else begin
        miss_count <= miss_count + 32'd1;
      end
    end else begin
      hit_count  <= hit_count;
      miss_count <= miss_count;
    end
  end
`endif

endmodule

// File: tb/tb_memory_hierarchy.sv
// Directed bench for memory_hierarchy: a tag/valid model of the direct-mapped
// cache predicts hit/miss, latency and data; a per-cycle process checks outputs.
module tb_memory_hierarchy;
  import memory_hierarchy_pkg::*;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead;
  logic [14:0] address;
  logic [31:0] data;
  logic        DataReady;
  logic        HMbar;
`ifdef MEMORY_HIERARCHY_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic        model_valid [256];
  logic [4:0]  model_tag   [256];
  logic        chk_en = 1'b0;
  logic [31:0] exp_data;
  logic        exp_hit;

  always #5 clk = ~clk;

  memory_hierarchy #(.MEM_LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .address   (address),
    .MemRead   (MemRead),
    .data      (data),
    .DataReady (DataReady),
    .HMbar     (HMbar)
`ifdef MEMORY_HIERARCHY_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every cycle a completed request is visible, data and HMbar must match the model.
  always @(negedge clk) begin
    if (chk_en && !rst && DataReady) begin
      check("cycle_data", data, exp_data);
      check("cycle_hmbar", {31'd0, HMbar}, {31'd0, exp_hit});
    end
  end

  task automatic model_clear();
    for (int i = 0; i < 256; i++) begin
      model_valid[i] = 1'b0;
      model_tag[i]   = 5'd0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    MemRead = 1'b0;
    #1;
    check("rst_ready", {31'd0, DataReady}, 32'd0);
    check("rst_hmbar", {31'd0, HMbar}, 32'd0);
    check("rst_data", data, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic do_read(input logic [14:0] a, input int hold,
                         output logic got_hit, output logic [31:0] got_data);
    int         cycles;
    logic [7:0] idx;
    logic [4:0] tg;
    idx      = a[9:2];
    tg       = a[14:10];
    exp_hit  = model_valid[idx] && (model_tag[idx] == tg);
    exp_data = {17'd0, a};
    address  = a;
    MemRead  = 1'b1;
    chk_en   = 1'b1;
    cycles   = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!DataReady && cycles < 20);
    check("latency", cycles, exp_hit ? 32'd1 : 32'(1 + LAT));
    got_hit  = HMbar;
    got_data = data;
    repeat (hold) begin
      @(negedge clk);
      check("hold_ready", {31'd0, DataReady}, 32'd1);
    end
    MemRead = 1'b0;
    @(negedge clk);
    check("ready_drop", {31'd0, DataReady}, 32'd0);
    model_valid[idx] = 1'b1;
    model_tag[idx]   = tg;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        h;
    logic [31:0] d;
    int          hits;
    int          misses;
    rst     = 1'b1;
    MemRead = 1'b0;
    address = 15'd0;
    model_clear();
    do_reset();

    // Cold miss then hit in the same block.
    do_read(15'h0400, 0, h, d);
    check("t1_miss_hmbar", {31'd0, h}, 32'd0);
    check("t1_miss_data", d, 32'h0000_0400);
    do_read(15'h0401, 0, h, d);
    check("t1_hit_hmbar", {31'd0, h}, 32'd1);
    check("t1_hit_data", d, 32'h0000_0401);

    // Sequential sweep from a clean cache.
    do_reset();
    hits   = 0;
    misses = 0;
    for (int a = 'h400; a <= 'h23FF; a++) begin
      do_read(15'(a), 0, h, d);
      if (h) hits++;
      else misses++;
    end
    check("t2_hits", 32'(hits), 32'd6144);
    check("t2_misses", 32'(misses), 32'd2048);
`ifdef MEMORY_HIERARCHY_STATS_EN
    check("t2_hit_count", hit_count, 32'd6144);
    check("t2_miss_count", miss_count, 32'd2048);
`endif

    // Conflict eviction on index 0.
    do_read(15'h0000, 0, h, d);
    check("t3_a_hmbar", {31'd0, h}, 32'd0);
    do_read(15'h0400, 0, h, d);
    check("t3_b_hmbar", {31'd0, h}, 32'd0);
    do_read(15'h0000, 0, h, d);
    check("t3_c_hmbar", {31'd0, h}, 32'd0);
    check("t3_c_data", d, 32'h0000_0000);

    // Hold MemRead in DONE; outputs must stay put.
    do_read(15'h0001, 5, h, d);
    check("t4_hmbar", {31'd0, h}, 32'd1);
    check("t4_data", d, 32'h0000_0001);

    // Reset in the middle of a fetch.
    @(negedge clk);
    address = 15'h1234;
    MemRead = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_fetch_ready", {31'd0, DataReady}, 32'd0);
    rst = 1'b1;
    #1;
    check("t5_rst_ready", {31'd0, DataReady}, 32'd0);
    check("t5_rst_data", data, 32'd0);
    MemRead = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    do_read(15'h1234, 0, h, d);
    check("t5_reread_hmbar", {31'd0, h}, 32'd0);
    check("t5_reread_data", d, 32'h0000_1234);
    do_read(15'h0001, 0, h, d);
    check("t5_flushed_hmbar", {31'd0, h}, 32'd0);

    // Top of the address space.
    do_read(15'h7FFF, 0, h, d);
    check("t6_miss_hmbar", {31'd0, h}, 32'd0);
    check("t6_miss_data", d, 32'h0000_7FFF);
    do_read(15'h7FFC, 0, h, d);
    check("t6_hit_hmbar", {31'd0, h}, 32'd1);
    check("t6_hit_data", d, 32'h0000_7FFC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_hierarchy.md
Name: memory_hierarchy

Overview:
- Read-only two-level memory: direct-mapped word cache in front of a 32K-word main memory.
- Serves one word read per MemRead handshake.
- Reports data, completion (DataReady) and whether the access hit in the cache (HMbar).
- Sits between a processor/test master and backing storage; there is no write path.

Parameters:
- ADDR_W, 15, word address width (32768 words of main memory)
- DATA_W, 32, word width
- INDEX_W, 8, cache index bits (256 lines)
- OFFSET_W, 2, word-in-block bits (4-word blocks; cache holds 1024 words)
- MEM_LATENCY, 4, main-memory block-fetch cycles on a miss (must be at least 1)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- address  input  ADDR_W  word address; must be stable while MemRead=1
- MemRead  input  1  read request, level-held by the master until DataReady is seen
- data  output  DATA_W  read word; valid while DataReady=1
- DataReady  output  1  request complete
- HMbar  output  1  1=hit, 0=miss; valid while DataReady=1

Behaviour:
- Address split: tag = address[14:10] (5 bits), index = address[9:2], offset = address[1:0].
- Each cache line holds a valid bit, a tag and 4 data words.
- Main memory: 32K x DATA_W, read-only. Contents are initialised at elaboration to mem[a] = a, zero-extended. Reset does not alter memory contents.
- Reset (async) forces:
  - FSM to IDLE
  - all valid bits to 0
  - DataReady=0, HMbar=0, data=0
  - fetch counter to 0
  - Reset mid-operation abandons any fetch; the line being filled stays invalid.
- FSM states: IDLE, FETCH, DONE.
- IDLE:
  - On a clk edge with MemRead=1, latch address.
  - If the line is valid and its tag matches: go to DONE, HMbar=1, data=cached word.
  - Otherwise: go to FETCH, counter=0.
- FETCH:
  - Counter increments each cycle.
  - At count MEM_LATENCY-1, write the whole 4-word block (base = address with offset zeroed) into the line, set valid, store the tag.
  - Then go to DONE with HMbar=0, data=requested word.
- DONE:
  - DataReady=1; data and HMbar held stable.
  - When MemRead=0 is sampled, go to IDLE and drop DataReady to 0 in that same transition.
- Latency (MemRead sampled to DataReady high): hit = 1 cycle; miss = 1 + MEM_LATENCY cycles.
- A new request is accepted only after a return to IDLE, so MemRead must drop for at least one clk edge between requests.
- MemRead dropping during FETCH does not abort the fetch. The fill completes; DONE is entered and exits on the next edge because MemRead is low.
- Conflict misses: same index with a different tag replaces the line (no associativity).
- Address wrap: none. The full 15-bit space is valid.
- Outputs are registered; no combinational path from address to data.

Optional Feature:
- Macro MEMORY_HIERARCHY_STATS_EN.
- When defined:
  - Adds outputs hit_count (32 bits) and miss_count (32 bits).
  - Each increments by 1 on entry to DONE with HMbar=1 or HMbar=0 respectively.
  - Both are cleared by rst.
- When undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package memory_hierarchy_pkg holds:
  - width constants ADDR_W, DATA_W, INDEX_W, OFFSET_W, TAG_W = ADDR_W-INDEX_W-OFFSET_W
  - state enum {IDLE, FETCH, DONE}
  - typedef of the cache-line struct (valid, tag, 4 words)
- One sub-module, main_memory:
  - Initialised storage with a block-read port (block address in, 4 words out).
- Cache array and FSM stay in the top module.

Test Plan:
1. Reset, then read 0x0400 -> miss: DataReady after 1+MEM_LATENCY cycles, HMbar=0, data=0x00000400. Then read 0x0401 -> hit after 1 cycle, HMbar=1, data=0x00000401.
2. Sequential reads 0x0400..0x23FF (8192 words), dropping MemRead between each -> 2048 misses, 6144 hits (75%), every data word equals its address. With STATS_EN, hit_count=6144 and miss_count=2048.
3. Read 0x0000 (miss), then 0x0400 (same index, different tag, miss), then 0x0000 again -> miss (line evicted), data=0x00000000.
4. Hold MemRead=1 in DONE for 5 cycles -> DataReady, data and HMbar stay constant. Drop MemRead -> DataReady=0 one cycle later.
5. Assert rst in the middle of FETCH for address 0x1234, release, then read 0x1234 -> DataReady=0 immediately on reset, and the re-read is a miss with data=0x00001234.
6. Read 0x7FFF -> miss, data=0x00007FFF. Then read 0x7FFC -> hit, data=0x00007FFC.
